// File: rtl/ilm_core_pipe.sv
// ilm_core_pipe -- pipelined improved-log-multiplier core.
//
// Sits downstream of the nearest-one detectors. Each beat carries operands
// A, B and their one-hot nearest-power-of-two vectors NA, NB. The core forms
//   P ~= 2^(ka+kb) + qa*2^kb + qb*2^ka,   qx = X - 2^kx (signed)
// over three register stages with a valid/ready handshake on both sides.
// Stalls collapse bubbles: a stage accepts new data whenever it is empty or
// its contents are moving on in the same cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr_err    synchronous clear of err_cnt (wins over an increment)
//   in_valid   input beat valid
//   in_ready   core can take a beat this cycle
//   in_a/in_b  unsigned operands
//   in_na/nb   one-hot nearest power of two (all-zero => operand is zero)
//   out_valid  result valid
//   out_ready  downstream takes the result
//   out_p      approximate product, unsigned 2W bits, saturated
//   out_err    beat had a multi-hot NA or NB (product forced to zero)
//   err_cnt    saturating count of accepted multi-hot beats
module ilm_core_pipe #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_na,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_nb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int K_W = $clog2(W);
  localparam int P_W = 2*W + 2;

  // Index of the set bit; for multi-hot input the result is meaningless,
  // but such beats are flagged and their product is forced to zero.
  function automatic logic [K_W-1:0] onehot_idx(input logic [W-1:0] oh);
    logic [K_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (oh[i]) idx = idx | K_W'(i);
    end
    return idx;
  endfunction

  // More than one bit set: clearing the lowest set bit leaves something.
  function automatic logic multi_hot(input logic [W-1:0] oh);
    return |(oh & (oh - W'(1)));
  endfunction

  // Clamp a signed sum into the unsigned product range.
  function automatic logic [2*W-1:0] sat_u(input logic signed [P_W-1:0] s);
    if (s[P_W-1])
      return '0;
    else if (|s[P_W-2:2*W])
      return '1;
    else
      return s[2*W-1:0];
  endfunction

  logic vld_p1, vld_p2, vld_p3;
  logic rdy_p2, rdy_p3;
  logic acc_p0;

  assign rdy_p3    = !vld_p3 || out_ready;
  assign rdy_p2    = !vld_p2 || rdy_p3;
  assign in_ready  = !vld_p1 || rdy_p2;
  assign acc_p0    = in_valid && in_ready;
  assign out_valid = vld_p3;

  logic err_p0;
  assign err_p0 = multi_hot(in_na) || multi_hot(in_nb);

  // ---- stage 1: register operands, encode one-hot, flag zero/err ----
  logic [W-1:0]   a_p1, b_p1;
  logic [K_W-1:0] ka_p1, kb_p1;
  logic           zero_p1, err_p1;

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      a_p1    <= in_a;
      b_p1    <= in_b;
      ka_p1   <= onehot_idx(in_na);
      kb_p1   <= onehot_idx(in_nb);
      zero_p1 <= (in_na == '0) || (in_nb == '0);
      err_p1  <= err_p0;
    end
  end

  // ---- stage 2: residues qa/qb and the three partial terms ----
  logic signed [W:0]     qa_c, qb_c;
  logic signed [P_W-1:0] qa_x, qb_x, base_c, ta_c, tb_c;
  logic [K_W:0]          kab_c;

  always_comb begin
    qa_c   = $signed({1'b0, a_p1}) - $signed({1'b0, W'(1) << ka_p1});
    qb_c   = $signed({1'b0, b_p1}) - $signed({1'b0, W'(1) << kb_p1});
    qa_x   = $signed({{(P_W-W-1){qa_c[W]}}, qa_c});
    qb_x   = $signed({{(P_W-W-1){qb_c[W]}}, qb_c});
    kab_c  = {1'b0, ka_p1} + {1'b0, kb_p1};
    base_c = $signed(P_W'(1) << kab_c);
    ta_c   = qa_x <<< kb_p1;
    tb_c   = qb_x <<< ka_p1;
  end

  logic signed [P_W-1:0] base_p2, ta_p2, tb_p2;
  logic                  kill_p2, err_p2;

  always_ff @(posedge clk) begin
    if (vld_p1 && rdy_p2) begin
      base_p2 <= base_c;
      ta_p2   <= ta_c;
      tb_p2   <= tb_c;
      kill_p2 <= zero_p1 || err_p1;
      err_p2  <= err_p1;
    end
  end

  // ---- stage 3: sum, clamp, output register ----
  logic signed [P_W-1:0] sum_c;
  assign sum_c = base_p2 + ta_p2 + tb_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p   <= '0;
      out_err <= 1'b0;
    end else if (vld_p2 && rdy_p3) begin
      out_p   <= kill_p2 ? '0 : sat_u(sum_c);
      out_err <= err_p2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (rdy_p2)   vld_p2 <= vld_p1;
      if (rdy_p3)   vld_p3 <= vld_p2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (clr_err)
      err_cnt <= '0;
    else if (acc_p0 && err_p0 && (err_cnt != '1))
      err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ilm_core_pipe.sv
// Directed testbench for ilm_core_pipe (W=8, CNT_W=8).
module tb_ilm_core_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_err;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_na, in_b, in_nb;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ilm_core_pipe #(.W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_err  (clr_err),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_na    (in_na),
    .in_b     (in_b),
    .in_nb    (in_nb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p),
    .out_err  (out_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, na, b, nb);
    in_valid = v;
    in_a = a; in_na = na; in_b = b; in_nb = nb;
  endtask

  // One beat with out_ready high: accept edge, then out_valid on the second
  // edge after it, gone again on the third.
  task automatic send_one(input string tag, input logic [7:0] a, na, b, nb,
                          input logic [15:0] ep, input logic ee, input logic [7:0] ecnt);
    drive(1'b1, a, na, b, nb);
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    check({tag, "_cnt"}, err_cnt, ecnt);
    check({tag, "_vld_e0"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_vld_e1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_p"}, out_p, ep);
    check({tag, "_err"}, out_err, ee);
    @(negedge clk);
    check({tag, "_vld_after"}, out_valid, 0);
  endtask

  logic [7:0]  bq_a [5] = '{8'd8,   8'd255, 8'd96,  8'd4,   8'd255};
  logic [7:0]  bq_na[5] = '{8'h08,  8'h80,  8'h80,  8'h04,  8'h01};
  logic [7:0]  bq_b [5] = '{8'd12,  8'd255, 8'd96,  8'd4,   8'd255};
  logic [7:0]  bq_nb[5] = '{8'h10,  8'h80,  8'h80,  8'h04,  8'h80};
  logic [15:0] bq_p [5] = '{16'd96, 16'd48896, 16'd8192, 16'd16, 16'd32767};

  initial begin
    int idx_in, idx_out, seen;
    logic acc, fire;

    rst_n = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_p",     out_p,     0);
    check("rst_out_err",   out_err,   0);
    check("rst_err_cnt",   err_cnt,   0);
    rst_n = 1'b1;
    @(negedge clk);

    send_one("basic",     8'd8,   8'h08, 8'd12,  8'h10, 16'd96,    1'b0, 8'd0);
    send_one("max",       8'd255, 8'h80, 8'd255, 8'h80, 16'd48896, 1'b0, 8'd0);
    send_one("neg_q",     8'd96,  8'h80, 8'd96,  8'h80, 16'd8192,  1'b0, 8'd0);
    send_one("asym",      8'd255, 8'h01, 8'd255, 8'h80, 16'd32767, 1'b0, 8'd0);
    send_one("clamp_neg", 8'd0,   8'h80, 8'd0,   8'h80, 16'd0,     1'b0, 8'd0);
    send_one("zero",      8'd0,   8'h00, 8'd200, 8'h80, 16'd0,     1'b0, 8'd0);
    send_one("multihot",  8'd6,   8'h06, 8'd5,   8'h04, 16'd0,     1'b1, 8'd1);

    // Backpressure: five beats offered, out_ready low for the first 6 cycles.
    idx_in = 0; idx_out = 0;
    drive(1'b1, bq_a[0], bq_na[0], bq_b[0], bq_nb[0]);
    for (int c = 0; c < 40 && idx_out < 5; c++) begin
      out_ready = (c >= 6);
      #1;
      if (c == 3) begin
        check("bp_full_in_ready", in_ready, 0);
        check("bp_accepted", idx_in, 3);
      end
      if (c == 5) begin
        check("bp_hold_vld", out_valid, 1);
        check("bp_hold_p", out_p, 16'd96);
      end
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        check($sformatf("bp_out%0d", idx_out), out_p, bq_p[idx_out]);
        idx_out++;
      end
      @(negedge clk);
      if (acc) idx_in++;
      if (idx_in < 5) drive(1'b1, bq_a[idx_in], bq_na[idx_in], bq_b[idx_in], bq_nb[idx_in]);
      else            drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    end
    check("bp_all_out", idx_out, 5);
    #1;
    check("bp_no_dup", out_valid, 0);
    @(negedge clk);

    // Error counter: clear, saturate, clear-priority.
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    check("clr_err", err_cnt, 0);
    drive(1'b1, 8'd6, 8'h06, 8'd5, 8'h04);
    for (int i = 0; i < 255; i++) @(negedge clk);
    check("cnt_reach", err_cnt, 255);
    @(negedge clk);
    check("cnt_sat", err_cnt, 255);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    check("clr_prio", err_cnt, 0);
    repeat (4) @(negedge clk);

    // Async reset with two beats in flight (one at the output, one behind it).
    drive(1'b1, 8'd8, 8'h08, 8'd12, 8'h10);
    @(negedge clk);
    drive(1'b1, 8'd4, 8'h04, 8'd4, 8'h04);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    check("pre_rst_vld", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld",   out_valid, 0);
    check("arst_ready", in_ready,  1);
    check("arst_p",     out_p,     0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
